// File: rtl/dma_fifo_burst_writer_if.sv
// Bundles the descriptor, FIFO read-side and memory-write handshake signals of the
// DMA burst writer. The master modport is the writer's view; slave is the environment's.
interface dma_fifo_burst_writer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 16
) ();
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  xfer_len;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_en;
  logic              mem_wr_valid;
  logic              mem_wr_ready;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_last;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  words_sent;

  modport master (
    input  start, start_addr, xfer_len, fifo_empty, fifo_rd_data, mem_wr_ready,
    output fifo_rd_en, mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_last, busy, done,
           words_sent
  );

  modport slave (
    output start, start_addr, xfer_len, fifo_empty, fifo_rd_data, mem_wr_ready,
    input  fifo_rd_en, mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_last, busy, done,
           words_sent
  );
endinterface

// File: rtl/dma_fifo_burst_writer.sv
// Read-side DMA stage: drains a FWFT FIFO into single-beat memory writes with sequential
// word addresses, flags burst ends, and pulses done once the last beat is accepted.
module dma_fifo_burst_writer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned BURST_LEN = 4
) (
  input logic                       rclk,
  input logic                       rrst_n,
  dma_fifo_burst_writer_if.master   bus_io
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [LEN_W-1:0] BeatMax = LEN_W'(BURST_LEN - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_valid_q, wr_valid_d;
  logic              wr_last_q, wr_last_d;
  logic [LEN_W-1:0]  pops_left_q, pops_left_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [LEN_W-1:0]  words_sent_q, words_sent_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              pop, accept, beat_last;

  // Pop only when the single output register is free or is being drained this cycle.
  always_comb begin
    accept    = wr_valid_q & bus_io.mem_wr_ready;
    pop       = (state_q == StRun) & ~bus_io.fifo_empty & (pops_left_q != '0) &
                (~wr_valid_q | bus_io.mem_wr_ready);
    beat_last = (beat_cnt_q == BeatMax) | (pops_left_q == LEN_W'(1));
  end

  // Next-state logic for the transfer FSM, output beat register and counters.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_valid_d   = wr_valid_q;
    wr_last_d    = wr_last_q;
    pops_left_d  = pops_left_q;
    remaining_d  = remaining_q;
    words_sent_d = words_sent_q;
    beat_cnt_d   = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          addr_d       = bus_io.start_addr;
          pops_left_d  = bus_io.xfer_len;
          remaining_d  = bus_io.xfer_len;
          words_sent_d = '0;
          beat_cnt_d   = '0;
          state_d      = (bus_io.xfer_len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (pop) begin
          wr_valid_d  = 1'b1;
          wr_data_d   = bus_io.fifo_rd_data;
          wr_addr_d   = addr_q;
          wr_last_d   = beat_last;
          addr_d      = addr_q + ADDR_W'(1);
          pops_left_d = pops_left_q - LEN_W'(1);
          beat_cnt_d  = beat_last ? '0 : beat_cnt_q + LEN_W'(1);
        end else if (accept) begin
          wr_valid_d = 1'b0;
        end
        if (accept) begin
          remaining_d  = remaining_q - LEN_W'(1);
          words_sent_d = words_sent_q + LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any transfer in flight.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_valid_q   <= 1'b0;
      wr_last_q    <= 1'b0;
      pops_left_q  <= '0;
      remaining_q  <= '0;
      words_sent_q <= '0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_valid_q   <= wr_valid_d;
      wr_last_q    <= wr_last_d;
      pops_left_q  <= pops_left_d;
      remaining_q  <= remaining_d;
      words_sent_q <= words_sent_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign bus_io.fifo_rd_en   = pop;
  assign bus_io.mem_wr_valid = wr_valid_q;
  assign bus_io.mem_wr_addr  = wr_addr_q;
  assign bus_io.mem_wr_data  = wr_data_q;
  assign bus_io.mem_wr_last  = wr_last_q;
  assign bus_io.busy         = (state_q != StIdle);
  assign bus_io.done         = (state_q == StDone);
  assign bus_io.words_sent   = words_sent_q;

endmodule
